// File: rtl/key_event_gen.sv
// key_event_gen: debounced per-key level plus press, release and auto-repeat pulses.
// Raw active-low buttons are synchronised and sampled on a shared slow tick.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   i_key_n       raw buttons, asynchronous, 0 = pressed
//   o_key_level   debounced state, 1 = pressed
//   o_key_press   1-clk pulse on accepted press
//   o_key_release 1-clk pulse on accepted release
//   o_key_repeat  1-clk pulse per auto-repeat while held
//   o_tick        1-clk sample strobe
module key_event_gen #(
    parameter int F_CLK          = 50_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int NUM_KEYS       = 6,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int HOLD_TICKS     = 500,
    parameter int REPEAT_TICKS   = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] i_key_n,
    output logic [NUM_KEYS-1:0] o_key_level,
    output logic [NUM_KEYS-1:0] o_key_press,
    output logic [NUM_KEYS-1:0] o_key_release,
    output logic [NUM_KEYS-1:0] o_key_repeat,
    output logic                o_tick
);

    localparam int DIV = F_CLK / TICK_HZ;
    localparam int TW  = $clog2(DIV);
    localparam int M1  = (DEBOUNCE_TICKS > HOLD_TICKS) ?
                         DEBOUNCE_TICKS : HOLD_TICKS;
    localparam int MAXT = (M1 > REPEAT_TICKS) ? M1 : REPEAT_TICKS;
    localparam int CW   = $clog2(MAXT + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [CW-1:0] DB_C      = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_TICKS);
    localparam logic [CW-1:0] REP_C     = CW'(REPEAT_TICKS);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRESS_DB = 3'd1;
    localparam logic [2:0] S_HELD     = 3'd2;
    localparam logic [2:0] S_REPEAT   = 3'd3;
    localparam logic [2:0] S_REL_DB   = 3'd4;

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [TW-1:0]       r_tick_cnt;
    logic                w_tick;

    // Synchronisers preset to "released" so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign o_tick = w_tick;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : gen_key
        logic [2:0]    r_state;
        logic [CW-1:0] r_cnt;
        logic          r_press;
        logic          r_rel;
        logic          r_rep;
        logic          w_p;
        logic [CW-1:0] w_inc;

        assign w_p   = ~r_sync2[g];
        assign w_inc = r_cnt + ONE_C;

        // Pulses default low every clk, so a pulse set on a tick edge
        // lasts exactly one clk.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_rep   <= 1'b0;
            end else begin
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_rep   <= 1'b0;
                if (w_tick) begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_p) begin
                                if (DEBOUNCE_TICKS == 1) begin
                                    r_state <= S_HELD;
                                    r_press <= 1'b1;
                                    r_cnt   <= '0;
                                end else begin
                                    r_state <= S_PRESS_DB;
                                    r_cnt   <= ONE_C;
                                end
                            end
                        end
                        S_PRESS_DB: begin
                            if (!w_p) begin
                                r_state <= S_IDLE;
                                r_cnt   <= '0;
                            end else if (w_inc == DB_C) begin
                                r_state <= S_HELD;
                                r_press <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= w_inc;
                            end
                        end
                        S_HELD, S_REPEAT: begin
                            if (!w_p) begin
                                if (DEBOUNCE_TICKS == 1) begin
                                    r_state <= S_IDLE;
                                    r_rel   <= 1'b1;
                                    r_cnt   <= '0;
                                end else begin
                                    r_state <= S_REL_DB;
                                    r_cnt   <= ONE_C;
                                end
                            end else if (w_inc == ((r_state == S_HELD) ?
                                                   HOLD_C : REP_C)) begin
                                r_state <= S_REPEAT;
                                r_rep   <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= w_inc;
                            end
                        end
                        S_REL_DB: begin
                            // A bounce back to pressed restarts the hold delay.
                            if (w_p) begin
                                r_state <= S_HELD;
                                r_cnt   <= '0;
                            end else if (w_inc == DB_C) begin
                                r_state <= S_IDLE;
                                r_rel   <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= w_inc;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end
        end

        assign o_key_level[g]   = (r_state == S_HELD) ||
                                  (r_state == S_REPEAT) ||
                                  (r_state == S_REL_DB);
        assign o_key_press[g]   = r_press;
        assign o_key_release[g] = r_rel;
        assign o_key_repeat[g]  = r_rep;
    end

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: randomized and directed scenarios for key_event_gen.
// A tick-level debounce/repeat model predicts every output each clk.
module tb_key_event_gen;

    localparam int NK   = 6;
    localparam int DB   = 3;
    localparam int HOLD = 5;
    localparam int REP  = 2;
    localparam int DIV  = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] o_key_level;
    logic [NK-1:0] o_key_press;
    logic [NK-1:0] o_key_release;
    logic [NK-1:0] o_key_repeat;
    logic          o_tick;

    int checks = 0;
    int failures = 0;

    key_event_gen #(
        .F_CLK(100), .TICK_HZ(10), .NUM_KEYS(NK),
        .DEBOUNCE_TICKS(DB), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_key_n(key_n),
        .o_key_level(o_key_level), .o_key_press(o_key_press),
        .o_key_release(o_key_release), .o_key_repeat(o_key_repeat),
        .o_tick(o_tick)
    );

    always #5 clk = ~clk;

    // Reference model: per key, count consecutive samples that disagree
    // with the accepted level, and count held ticks since acceptance.
    int            m_cnt;
    logic [NK-1:0] e_level, e_press, e_rel, e_rep;
    int            prun [NK];
    int            rrun [NK];
    int            age  [NK];
    bit            m_p;
    logic          e_tick;

    assign e_tick = (m_cnt == DIV - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            e_level = '0; e_press = '0; e_rel = '0; e_rep = '0;
            for (int k = 0; k < NK; k++) begin
                prun[k] = 0; rrun[k] = 0; age[k] = 0;
            end
        end else begin
            e_press = '0; e_rel = '0; e_rep = '0;
            if (m_cnt == DIV - 1) begin
                for (int k = 0; k < NK; k++) begin
                    m_p = !key_n[k];
                    if (!e_level[k]) begin
                        if (m_p) begin
                            prun[k]++;
                            if (prun[k] == DB) begin
                                e_level[k] = 1'b1; e_press[k] = 1'b1;
                                prun[k] = 0; age[k] = 0;
                            end
                        end else prun[k] = 0;
                    end else if (m_p) begin
                        if (rrun[k] > 0) begin
                            rrun[k] = 0; age[k] = 0;
                        end else begin
                            age[k]++;
                            if (age[k] >= HOLD && (age[k] - HOLD) % REP == 0)
                                e_rep[k] = 1'b1;
                        end
                    end else begin
                        rrun[k]++;
                        if (rrun[k] == DB) begin
                            e_level[k] = 1'b0; e_rel[k] = 1'b1; rrun[k] = 0;
                        end
                    end
                end
            end
            m_cnt = (m_cnt + 1) % DIV;
        end
    end

    logic [4*NK:0] w_obs, w_exp;
    assign w_obs = {o_key_level, o_key_press, o_key_release, o_key_repeat, o_tick};
    assign w_exp = {e_level, e_press, e_rel, e_rep, e_tick};

    // Leaves the bench at the negedge just after a tick edge.
    task automatic sync_tick();
        int n = 0;
        @(negedge clk);
        while (!e_tick && n < 3 * DIV) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int nt = 0, first = -1;
        key_n = '1;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== '0) begin
                failures++;
                $display("FAIL reset_hold got=%h want=0", w_obs);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== w_exp) begin
                failures++;
                $display("FAIL reset_cyc c=%0d got=%h want=%h", c, w_obs, w_exp);
            end
            if (o_tick) begin
                nt++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (nt !== 3 || first !== 8) begin
            failures++;
            $display("FAIL reset_tick got n=%0d first=%0d want n=3 first=8", nt, first);
        end
    endtask

    task automatic test_clean_press();
        int np = 0, at = -1, other = 0;
        logic [NK-1:0] lvl = '0;
        sync_tick();
        for (int t = 0; t < 12; t++) begin
            key_n = (t < 8) ? 6'b111110 : 6'b111111;
            for (int c = 0; c < DIV; c++) begin
                checks++;
                if (w_obs !== w_exp) begin
                    failures++;
                    $display("FAIL press_cyc t=%0d c=%0d got=%h want=%h", t, c, w_obs, w_exp);
                end
                if (o_key_press[0]) begin np++; at = t; end
                if (o_key_press[NK-1:1] != 0) other++;
                if (t == 7 && c == 0) lvl = o_key_level;
                @(negedge clk);
            end
        end
        checks++;
        if (np !== 1 || at !== 3 || other !== 0) begin
            failures++;
            $display("FAIL press_pulse got n=%0d at=%0d oth=%0d want 1 3 0", np, at, other);
        end
        checks++;
        if (lvl !== 6'b000001) begin
            failures++;
            $display("FAIL press_level got=%b want=000001", lvl);
        end
    endtask

    task automatic test_bounce();
        int np1 = 0, at = -1, np2 = 0;
        bit pr;
        sync_tick();
        for (int t = 0; t < 16; t++) begin
            pr = (t < 2) || (t >= 3 && t < 6) || (t == 11);
            key_n = pr ? 6'b111101 : 6'b111111;
            for (int c = 0; c < DIV; c++) begin
                checks++;
                if (w_obs !== w_exp) begin
                    failures++;
                    $display("FAIL bounce_cyc t=%0d c=%0d got=%h want=%h", t, c, w_obs, w_exp);
                end
                if (o_key_press[1]) begin
                    if (t <= 10) begin np1++; at = t; end
                    else np2++;
                end
                @(negedge clk);
            end
        end
        checks++;
        if (np1 !== 1 || at !== 6) begin
            failures++;
            $display("FAIL bounce_press got n=%0d at=%0d want n=1 at=6", np1, at);
        end
        checks++;
        if (np2 !== 0) begin
            failures++;
            $display("FAIL glitch_press got n=%0d want 0", np2);
        end
    endtask

    task automatic test_long_press();
        int nr = 0, first = -1, nrel = 0, rat = -1;
        sync_tick();
        for (int t = 0; t < 28; t++) begin
            key_n = (t < 23) ? 6'b111011 : 6'b111111;
            for (int c = 0; c < DIV; c++) begin
                checks++;
                if (w_obs !== w_exp) begin
                    failures++;
                    $display("FAIL long_cyc t=%0d c=%0d got=%h want=%h", t, c, w_obs, w_exp);
                end
                if (o_key_repeat[2]) begin
                    nr++;
                    if (first < 0) first = t;
                end
                if (o_key_release[2]) begin nrel++; rat = t; end
                @(negedge clk);
            end
        end
        checks++;
        if (nr !== 8 || first !== 8) begin
            failures++;
            $display("FAIL long_repeat got n=%0d first=%0d want n=8 first=8", nr, first);
        end
        checks++;
        if (nrel !== 1 || rat !== 26 || o_key_level[2] !== 1'b0) begin
            failures++;
            $display("FAIL long_release got n=%0d at=%0d lvl=%b want 1 26 0",
                     nrel, rat, o_key_level[2]);
        end
    endtask

    task automatic test_release_bounce();
        int np = 0, nrel = 0, rat = -1, drop = 0;
        bit pr;
        sync_tick();
        for (int t = 0; t < 15; t++) begin
            pr = (t < 5) || (t >= 7 && t < 10);
            key_n = pr ? 6'b110111 : 6'b111111;
            for (int c = 0; c < DIV; c++) begin
                checks++;
                if (w_obs !== w_exp) begin
                    failures++;
                    $display("FAIL relb_cyc t=%0d c=%0d got=%h want=%h", t, c, w_obs, w_exp);
                end
                if (o_key_press[3]) np++;
                if (o_key_release[3]) begin nrel++; rat = t; end
                if (t >= 3 && t < 13 && !o_key_level[3]) drop++;
                @(negedge clk);
            end
        end
        checks++;
        if (np !== 1 || drop !== 0) begin
            failures++;
            $display("FAIL relb_level got press=%0d drops=%0d want 1 0", np, drop);
        end
        checks++;
        if (nrel !== 1 || rat !== 13) begin
            failures++;
            $display("FAIL relb_release got n=%0d at=%0d want n=1 at=13", nrel, rat);
        end
    endtask

    task automatic test_simultaneous_reset();
        int both = 0, single = 0, at = -1, nrel = 0;
        sync_tick();
        for (int t = 0; t < 6; t++) begin
            key_n = 6'b111100;
            for (int c = 0; c < DIV; c++) begin
                checks++;
                if (w_obs !== w_exp) begin
                    failures++;
                    $display("FAIL simul_cyc t=%0d c=%0d got=%h want=%h", t, c, w_obs, w_exp);
                end
                if (o_key_press[1:0] == 2'b11) both++;
                if (^o_key_press[1:0]) single++;
                @(negedge clk);
            end
        end
        checks++;
        if (both !== 1 || single !== 0) begin
            failures++;
            $display("FAIL simul_press got both=%0d single=%0d want 1 0", both, single);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (w_obs !== '0) begin
            failures++;
            $display("FAIL midreset_now got=%h want=0", w_obs);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (o_key_release != 0) nrel++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (o_key_release != 0) nrel++;
        end
        checks++;
        if (nrel !== 0) begin
            failures++;
            $display("FAIL midreset_release got n=%0d want 0", nrel);
        end
        both = 0;
        sync_tick();
        for (int t = 0; t < 10; t++) begin
            key_n = (t < 6) ? 6'b111100 : 6'b111111;
            for (int c = 0; c < DIV; c++) begin
                checks++;
                if (w_obs !== w_exp) begin
                    failures++;
                    $display("FAIL reacc_cyc t=%0d c=%0d got=%h want=%h", t, c, w_obs, w_exp);
                end
                if (o_key_press[1:0] == 2'b11) begin both++; at = t; end
                @(negedge clk);
            end
        end
        checks++;
        if (both !== 1 || at !== 2) begin
            failures++;
            $display("FAIL reaccept got n=%0d at=%0d want n=1 at=2", both, at);
        end
    endtask

    task automatic test_random();
        logic [NK-1:0] kn = '1;
        int npulse = 0;
        sync_tick();
        for (int t = 0; t < 90; t++) begin
            if (t < 85) begin
                for (int k = 0; k < NK; k++)
                    if ($urandom_range(0, 3) == 0) kn[k] = ~kn[k];
            end else kn = '1;
            key_n = kn;
            for (int c = 0; c < DIV; c++) begin
                checks++;
                if (w_obs !== w_exp) begin
                    failures++;
                    $display("FAIL random_cyc t=%0d c=%0d got=%h want=%h", t, c, w_obs, w_exp);
                end
                if ((o_key_press & o_key_release) != 0 ||
                    (o_key_press & o_key_repeat) != 0 ||
                    (o_key_release & o_key_repeat) != 0) npulse++;
                @(negedge clk);
            end
        end
        checks++;
        if (npulse !== 0) begin
            failures++;
            $display("FAIL random_exclusive got n=%0d want 0", npulse);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = '1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_bounce();
        test_simultaneous_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
